// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU normalise/round/pack path.
package fpu_pkg;

  localparam int unsigned FP_BIAS    = 127;
  localparam int unsigned FP_POINT   = 30;
  localparam logic [7:0]  FP_EXP_INF = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [31:0] mantissa;
    logic [4:0]  dest;
  } fpu_unpacked_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fpu_flags_t;

endpackage

// File: rtl/fpu_normalize_if.sv
// Operand/result bundle between the int->float converter, the normaliser and writeback.
interface fpu_normalize_if;
  import fpu_pkg::*;

  logic        in_valid;
  logic [31:0] in_mantissa;
  logic [7:0]  in_exponent;
  logic        in_sign;
  logic [4:0]  in_dest;

  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  fpu_flags_t  out_flags;

  modport master (
    output in_valid, in_mantissa, in_exponent, in_sign, in_dest,
    input  out_valid, out_result, out_dest, out_flags
  );

  modport slave (
    input  in_valid, in_mantissa, in_exponent, in_sign, in_dest,
    output out_valid, out_result, out_dest, out_flags
  );

endinterface

// File: rtl/fpu_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input yields 32.
module fpu_lzc32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Scan upward so the most significant set bit is the last one to win.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fpu_normalize.sv
// Three-stage normalise, round-to-nearest-even and pack into an IEEE-754 single.
module fpu_normalize #(
  parameter int unsigned FP_POINT  = 30,
  parameter int unsigned FLUSH_DEN = 1
) (
  input logic             clock,
  input logic             reset_n,
  fpu_normalize_if.slave  bus
);
  import fpu_pkg::*;

  if (FLUSH_DEN != 1) begin : g_flush_den_check
    $error("fpu_normalize: only FLUSH_DEN = 1 (flush to zero) is supported");
  end

  // Exponent shift from the FP_POINT reference to a leading 1 at bit 31.
  localparam logic signed [9:0] ExpAdj = 10'(32'sd31 - int'(FP_POINT));

  // S1: leading-zero count
  logic          s1_valid_q, s1_zero_q;
  fpu_unpacked_t s1_op_q, s1_op_d;
  logic [5:0]    lzc, s1_lzc_q;

  fpu_lzc32 u_lzc (
    .value (bus.in_mantissa),
    .count (lzc)
  );

  assign s1_op_d = '{sign:     bus.in_sign,
                     exponent: bus.in_exponent,
                     mantissa: bus.in_mantissa,
                     dest:     bus.in_dest};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_op_q    <= '0;
      s1_lzc_q   <= '0;
    end else begin
      s1_valid_q <= bus.in_valid;
      s1_zero_q  <= (bus.in_mantissa == 32'd0);
      s1_op_q    <= s1_op_d;
      s1_lzc_q   <= lzc;
    end
  end

  // S2: shift; bit 31 is the implicit leading 1 and is not carried forward
  logic                s2_valid_q, s2_zero_q, s2_sign_q;
  logic [4:0]          s2_dest_q;
  logic [30:0]         man_n_d, s2_man_q;
  logic signed [9:0]   exp_n_d, s2_exp_q;

  assign man_n_d = 31'(s1_op_q.mantissa << s1_lzc_q);
  assign exp_n_d = $signed({2'b00, s1_op_q.exponent}) + ExpAdj - $signed({4'b0000, s1_lzc_q});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_dest_q  <= '0;
      s2_man_q   <= '0;
      s2_exp_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_zero_q  <= s1_zero_q;
      s2_sign_q  <= s1_op_q.sign;
      s2_dest_q  <= s1_op_q.dest;
      s2_man_q   <= man_n_d;
      s2_exp_q   <= exp_n_d;
    end
  end

  // S3: round and pack
  logic [22:0]       frac;
  logic              guard, sticky, round_up, carry;
  logic [23:0]       frac_sum;
  logic signed [9:0] exp_final;
  logic [31:0]       result_d, result_q;
  fpu_flags_t        flags_d, flags_q;
  logic              valid_q;
  logic [4:0]        dest_q;

  assign frac      = s2_man_q[30:8];
  assign guard     = s2_man_q[7];
  assign sticky    = |s2_man_q[6:0];
  assign round_up  = guard & (sticky | frac[0]);
  assign frac_sum  = {1'b0, frac} + {23'd0, round_up};
  assign carry     = frac_sum[23];
  assign exp_final = s2_exp_q + $signed({9'd0, carry});

  always_comb begin
    result_d = {s2_sign_q, exp_final[7:0], frac_sum[22:0]};
    flags_d  = '0;
    if (s2_zero_q) begin
      result_d = {s2_sign_q, 31'd0};
    end else if (exp_final >= 10'sd255) begin
      result_d          = {s2_sign_q, FP_EXP_INF, 23'd0};
      flags_d.overflow  = 1'b1;
      flags_d.inexact   = 1'b1;
    end else if (exp_final <= 10'sd0) begin
      result_d          = {s2_sign_q, 31'd0};
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
    end else begin
      flags_d.inexact   = guard | sticky;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      dest_q   <= '0;
      flags_q  <= '0;
    end else begin
      valid_q  <= s2_valid_q;
      result_q <= result_d;
      dest_q   <= s2_dest_q;
      flags_q  <= flags_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_dest   = dest_q;
  assign bus.out_flags  = flags_q;

endmodule

// File: tb/tb_fpu_normalize.sv
// Directed bench for fpu_normalize: reset values, single ops, streaming and mid-stream reset.
module tb_fpu_normalize;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  fpu_normalize_if bus ();

  fpu_normalize dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] mant;
    logic [7:0]  expo;
    logic        sign;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  vec_t vecs [10];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic drive(input int i, input logic [4:0] dest);
    bus.in_valid    = 1'b1;
    bus.in_mantissa = vecs[i].mant;
    bus.in_exponent = vecs[i].expo;
    bus.in_sign     = vecs[i].sign;
    bus.in_dest     = dest;
  endtask

  task automatic check_out(input string tag, input int i, input logic [4:0] dest);
    check_eq($sformatf("%s valid", tag), {31'd0, bus.out_valid}, 32'd1);
    check_eq($sformatf("%s result", tag), bus.out_result, vecs[i].res);
    check_eq($sformatf("%s flags", tag), {29'd0, bus.out_flags}, {29'd0, vecs[i].flg});
    check_eq($sformatf("%s dest", tag), {27'd0, bus.out_dest}, {27'd0, dest});
  endtask

  // One isolated op: nothing before edge N+3, valid for exactly one cycle after it.
  task automatic run_single(input int i, input logic [4:0] dest);
    string tag;
    tag = $sformatf("single%0d", i);
    @(posedge clock); #1;
    drive(i, dest);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    check_eq({tag, " early1"}, {31'd0, bus.out_valid}, 32'd0);
    @(posedge clock); #1;
    check_eq({tag, " early2"}, {31'd0, bus.out_valid}, 32'd0);
    @(posedge clock); #1;
    check_out(tag, i, dest);
    @(posedge clock); #1;
    check_eq({tag, " one-cycle"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //            mantissa      exp     sign  result        {ovf,unf,inx}
    vecs[0] = '{32'h00000001, 8'd157, 1'b0, 32'h3F800000, 3'b000};
    vecs[1] = '{32'h00000001, 8'd157, 1'b1, 32'hBF800000, 3'b000};
    vecs[2] = '{32'h80000000, 8'd157, 1'b1, 32'hCF000000, 3'b000};
    vecs[3] = '{32'h00000000, 8'd157, 1'b0, 32'h00000000, 3'b000};
    vecs[4] = '{32'h01000001, 8'd157, 1'b0, 32'h4B800000, 3'b001};
    vecs[5] = '{32'h01000003, 8'd157, 1'b0, 32'h4B800002, 3'b001};
    vecs[6] = '{32'h7FFFFFFF, 8'd157, 1'b0, 32'h4F000000, 3'b001};
    vecs[7] = '{32'h80000000, 8'd254, 1'b0, 32'h7F800000, 3'b101};
    vecs[8] = '{32'h00000001, 8'd2,   1'b0, 32'h00000000, 3'b011};
    vecs[9] = '{32'h00000000, 8'd157, 1'b1, 32'h80000000, 3'b000};

    reset_n         = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_mantissa = '0;
    bus.in_exponent = '0;
    bus.in_sign     = 1'b0;
    bus.in_dest     = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("reset result", bus.out_result, 32'd0);
    check_eq("reset dest", {27'd0, bus.out_dest}, 32'd0);
    check_eq("reset flags", {29'd0, bus.out_flags}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_single(i, 5'(i + 16));

    // Eight back-to-back ops; op driven in iteration k is sampled in iteration k+3.
    for (int k = 0; k < 14; k++) begin
      @(posedge clock); #1;
      check_eq($sformatf("stream%0d valid", k), {31'd0, bus.out_valid},
               {31'd0, (k >= 3 && k < 11)});
      if (k >= 3 && k < 11) check_out($sformatf("stream op%0d", k - 3), k - 3, 5'(k - 3));
      if (k < 8) drive(k, 5'(k));
      else bus.in_valid = 1'b0;
    end

    // Fill the pipe, then reset with ops in flight.
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      drive(k, 5'(k));
    end
    @(posedge clock); #1;
    check_eq("pre-reset valid", {31'd0, bus.out_valid}, 32'd1);
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("async reset valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("async reset result", bus.out_result, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      check_eq($sformatf("post-reset idle%0d", k), {31'd0, bus.out_valid}, 32'd0);
    end
    run_single(5, 5'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
